// File: rtl/demux_nline_reg.sv
// Registered 1-to-N word demultiplexer with unicast and broadcast routing.
// Each output channel has a one-entry holding register with a valid/ready handshake.
module demux_nline_reg #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   err_sel,
    input  logic                   err_clr
);

    logic [N_OUT-1:0] can_take;
    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] load;
    logic             sel_ok;
    logic             accept;

    // An out-of-range select hits no channel, so the word is simply dropped.
    always_comb begin
        can_take = ~out_valid | out_ready;
        for (int k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
        sel_ok = |sel_hit;

        if (!rst_n) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &can_take;
        end else if (sel_ok) begin
            in_ready = |(sel_hit & can_take);
        end else begin
            in_ready = 1'b1;
        end

        accept = in_valid & in_ready;
        if (!accept) begin
            load = '0;
        end else if (in_bcast) begin
            load = '1;
        end else begin
            load = sel_hit;
        end
    end

    // A reload takes priority over a drain so a streaming consumer sees no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    out_valid[k]                <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]  <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Setting wins over clearing when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
        end else if (accept && !in_bcast && !sel_ok) begin
            err_sel <= 1'b1;
        end else if (err_clr) begin
            err_sel <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_nline_reg.sv
// Bench for demux_nline_reg: default build driven directed and randomly against a
// channel-array model, plus a 3-channel build and a 16-bit 8-channel build.
module tb_demux_nline_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default build: WIDTH=8, N_OUT=4
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast, in_valid, in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid, out_ready;
    logic        err_sel, err_clr;

    // Three-channel build for out-of-range selects
    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic        b_bcast, b_valid, b_ready;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_valid, b_out_ready;
    logic        b_err, b_err_clr;

    // Wide build for the asynchronous reset
    logic         c_rst_n;
    logic [15:0]  c_data;
    logic [2:0]   c_sel;
    logic         c_bcast, c_valid, c_ready;
    logic [127:0] c_out_data;
    logic [7:0]   c_out_valid, c_out_ready;
    logic         c_err, c_err_clr;

    demux_nline_reg dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_sel(err_sel), .err_clr(err_clr)
    );

    demux_nline_reg #(.WIDTH(8), .N_OUT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel),
        .in_bcast(b_bcast), .in_valid(b_valid), .in_ready(b_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_sel(b_err), .err_clr(b_err_clr)
    );

    demux_nline_reg #(.WIDTH(16), .N_OUT(8)) dut2 (
        .clk(clk), .rst_n(c_rst_n), .in_data(c_data), .in_sel(c_sel),
        .in_bcast(c_bcast), .in_valid(c_valid), .in_ready(c_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .err_sel(c_err), .err_clr(c_err_clr)
    );

    // Model of the default build: one holding slot per channel
    logic [7:0] m_data [4];
    bit         m_valid [4];
    logic       last_ready;

    function automatic bit modelReady();
        if (!rst_n) return 1'b0;
        if (in_bcast) begin
            for (int k = 0; k < 4; k++)
                if (m_valid[k] && !out_ready[k]) return 1'b0;
            return 1'b1;
        end
        return !m_valid[in_sel] || out_ready[in_sel];
    endfunction

    task automatic modelEdge();
        bit acc;
        acc = in_valid && modelReady();
        for (int k = 0; k < 4; k++) begin
            if (acc && (in_bcast || in_sel == k)) begin
                m_valid[k] = 1'b1;
                m_data[k]  = in_data;
            end else if (out_ready[k]) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [3:0]  ev;
        logic [31:0] ed;
        for (int k = 0; k < 4; k++) begin
            ev[k]          = m_valid[k];
            ed[k*8 +: 8]   = m_data[k];
        end
        checkOutput({tag, "_valid"}, out_valid, ev);
        checkOutput({tag, "_data"}, out_data, ed);
        checkOutput({tag, "_err"}, err_sel, 1'b0);
    endtask

    // Called just after a rising edge: apply inputs, check in_ready mid-cycle, clock, check outputs
    task automatic applyStimulus(input string tag, input logic [7:0] d, input logic [1:0] s,
                                 input logic b, input logic v, input logic [3:0] r);
        in_data   = d;
        in_sel    = s;
        in_bcast  = b;
        in_valid  = v;
        out_ready = r;
        #3;
        last_ready = in_ready;
        checkOutput({tag, "_rdy"}, in_ready, modelReady());
        modelEdge();
        @(posedge clk);
        #1;
        checkModel(tag);
    endtask

    initial begin
        rst_n = 1'b0; c_rst_n = 1'b0;
        in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b1; out_ready = '0; err_clr = 1'b0;
        b_data = '0; b_sel = '0; b_bcast = 1'b0; b_valid = 1'b0; b_out_ready = '0; b_err_clr = 1'b0;
        c_data = '0; c_sel = '0; c_bcast = 1'b0; c_valid = 1'b0; c_out_ready = '0; c_err_clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", out_valid, 4'b0000);
        checkOutput("rst_data", out_data, 32'h0);
        checkOutput("rst_err", err_sel, 1'b0);
        checkOutput("rst_rdy", in_ready, 1'b0);
        rst_n = 1'b1; c_rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] unicast after reset");
        applyStimulus("t1", 8'h07, 2'd2, 1'b0, 1'b1, 4'b0000);
        checkOutput("t1_v", out_valid, 4'b0100);
        checkOutput("t1_d", out_data, 32'h0007_0000);

        $display("[TB] backpressure");
        applyStimulus("t2a", 8'h11, 2'd1, 1'b0, 1'b1, 4'b0000);
        applyStimulus("t2b", 8'hA5, 2'd1, 1'b0, 1'b1, 4'b0000);
        checkOutput("t2_blocked", last_ready, 1'b0);
        checkOutput("t2_hold", out_data[15:8], 8'h11);
        applyStimulus("t2c", 8'hA5, 2'd1, 1'b0, 1'b1, 4'b0010);
        checkOutput("t2_open", last_ready, 1'b1);
        checkOutput("t2_d", out_data[15:8], 8'hA5);
        checkOutput("t2_v", out_valid[1], 1'b1);

        $display("[TB] broadcast");
        applyStimulus("t3a", 8'h00, 2'd0, 1'b0, 1'b0, 4'b1111);
        checkOutput("t3_empty", out_valid, 4'b0000);
        applyStimulus("t3b", 8'h3C, 2'd1, 1'b1, 1'b1, 4'b0000);
        checkOutput("t3_v", out_valid, 4'b1111);
        checkOutput("t3_d", out_data, 32'h3C3C_3C3C);
        applyStimulus("t3c", 8'h5A, 2'd0, 1'b1, 1'b1, 4'b0000);
        checkOutput("t3_blocked", last_ready, 1'b0);
        checkOutput("t3_hold", out_data, 32'h3C3C_3C3C);

        $display("[TB] streaming");
        applyStimulus("t4a", 8'h00, 2'd0, 1'b0, 1'b0, 4'b1111);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus("t4", 8'(i), 2'd0, 1'b0, 1'b1, 4'b0001);
            checkOutput("t4_rdy1", last_ready, 1'b1);
            checkOutput("t4_d", out_data[7:0], 8'(i));
            checkOutput("t4_v", out_valid[0], 1'b1);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            err_clr = 1'($urandom);
            applyStimulus("rnd", 8'($urandom), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 4'($urandom));
        end
        in_valid = 1'b0; out_ready = '0; err_clr = 1'b0;

        $display("[TB] out-of-range select on three channels");
        b_data = 8'h9C; b_sel = 2'd2; b_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("t5_top_v", b_out_valid, 3'b100);
        checkOutput("t5_top_d", b_out_data, 24'h9C_0000);
        b_data = 8'h44; b_sel = 2'd3; b_valid = 1'b1;
        #3;
        checkOutput("t5_rdy", b_ready, 1'b1);
        @(posedge clk); #1;
        checkOutput("t5_err", b_err, 1'b1);
        checkOutput("t5_v", b_out_valid, 3'b100);
        checkOutput("t5_d", b_out_data, 24'h9C_0000);
        b_err_clr = 1'b1;
        @(posedge clk); #1;
        checkOutput("t5_setwins", b_err, 1'b1);
        b_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_clr", b_err, 1'b0);
        b_err_clr = 1'b0;

        $display("[TB] asynchronous reset mid-transfer");
        c_data = 16'hBEEF; c_sel = 3'd0; c_valid = 1'b1;
        @(posedge clk); #1;
        c_data = 16'h1234; c_sel = 3'd5;
        @(posedge clk); #1;
        c_valid = 1'b0;
        checkOutput("t6_fill_v", c_out_valid, 8'b0010_0001);
        checkOutput("t6_fill_d5", c_out_data[95:80], 16'h1234);
        checkOutput("t6_fill_d0", c_out_data[15:0], 16'hBEEF);
        #2;
        c_valid = 1'b1;
        c_rst_n = 1'b0;
        #1;
        checkOutput("t6_v", c_out_valid, 8'h00);
        checkOutput("t6_d", c_out_data, 128'h0);
        checkOutput("t6_rdy", c_ready, 1'b0);
        @(posedge clk); #1;
        c_valid = 1'b0;
        c_rst_n = 1'b1;

        checkModel("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
